// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register chain for the RV32I core.
// Carries a data bundle and a control bundle through DEPTH stages with a
// valid bit each. Stall holds the chain, flush turns every stage into a bubble,
// and occupancy reports how many stages hold a live instruction.
module pipe_stage_reg #(
    parameter int DATA_W     = 96,
    parameter int CTRL_W     = 8,
    parameter int DEPTH      = 1,
    parameter int FLUSH_DATA = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // Stage 0 is the entry stage; stage DEPTH-1 drives the outputs.
    logic [DEPTH-1:0]             vld;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [OCC_W-1:0]             occ_cnt;

    // Valid and control: flush kills everything, stall freezes, otherwise shift.
    // Bubbles capture zero control so they can never write state downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld    <= '0;
            ctrl_q <= '0;
        end else if (flush) begin
            vld    <= '0;
            ctrl_q <= '0;
        end else if (!stall) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                vld[i]    <= vld[i-1];
                ctrl_q[i] <= ctrl_q[i-1];
            end
            vld[0]    <= in_valid;
            ctrl_q[0] <= in_valid ? in_ctrl : '0;
        end
    end

    // Data shifts alongside valid; on flush it is only cleared when FLUSH_DATA
    // is set, otherwise the stale payload is left in place (it is unqualified).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (flush) begin
            if (FLUSH_DATA != 0) begin
                data_q <= '0;
            end
        end else if (!stall) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                data_q[i] <= data_q[i-1];
            end
            data_q[0] <= in_data;
        end
    end

    // Occupancy is a population count of the current valid bits.
    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_cnt = occ_cnt + OCC_W'(vld[i]);
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_ctrl  = vld[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;
    assign occupancy = occ_cnt;

endmodule
